// File: rtl/fp_wb_queue_if.sv
// Port bundle for the FPU writeback queue.
// slave is the queue side; master is the FPU, regfile and issue side.
interface fp_wb_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [4:0]        in_rd_i;
  logic              in_int_i;
  logic [4:0]        in_status_i;
  logic              flush_i;
  logic              fp_we_o;
  logic [4:0]        fp_waddr_o;
  logic [DATA_W-1:0] fp_wdata_o;
  logic              int_valid_o;
  logic              int_ready_i;
  logic [4:0]        int_waddr_o;
  logic [DATA_W-1:0] int_wdata_o;
  logic [4:0]        chk_rd_i;
  logic              chk_hit_o;
  logic [4:0]        fflags_o;
  logic              fflags_clr_i;
  logic [CNT_W-1:0]  count_o;
  logic              busy_o;

  modport slave (
    input  in_valid_i, in_data_i, in_rd_i, in_int_i, in_status_i, flush_i,
    input  int_ready_i, chk_rd_i, fflags_clr_i,
    output in_ready_o, fp_we_o, fp_waddr_o, fp_wdata_o, int_valid_o,
    output int_waddr_o, int_wdata_o, chk_hit_o, fflags_o, count_o, busy_o
  );

  modport master (
    output in_valid_i, in_data_i, in_rd_i, in_int_i, in_status_i, flush_i,
    output int_ready_i, chk_rd_i, fflags_clr_i,
    input  in_ready_o, fp_we_o, fp_waddr_o, fp_wdata_o, int_valid_o,
    input  int_waddr_o, int_wdata_o, chk_hit_o, fflags_o, count_o, busy_o
  );
endinterface

// File: rtl/fp_wb_queue.sv
// In-order writeback FIFO behind the FPU: drains to the FP regfile or integer port,
// tracks pending FP destinations, and accrues IEEE flags when FP_WB_FFLAGS_EN is defined.
module fp_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  fp_wb_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Handshakes: input side transfers on in_valid_i && in_ready_o (in_ready_o is
  // registered-state only); integer side transfers on int_valid_o && int_ready_i,
  // and int_valid_o with its payload holds until that transfer; FP side always accepts.
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [4:0]        r_rd   [DEPTH];
  logic [DEPTH-1:0]  r_int;

  logic [PTR_W-1:0]  w_count;
  logic [IDX_W-1:0]  w_head_idx, w_wr_idx;
  logic              w_head_valid, w_head_int, w_full;
  logic              w_push, w_pop, w_fp_we, w_int_valid, w_hit;

  assign w_count      = r_wptr - r_rptr;
  assign w_head_idx   = r_rptr[IDX_W-1:0];
  assign w_wr_idx     = r_wptr[IDX_W-1:0];
  assign w_head_valid = (w_count != '0);
  assign w_head_int   = r_int[w_head_idx];
  assign w_full       = (w_count == PTR_W'(DEPTH));

  assign w_push      = bus.in_valid_i && !w_full && !bus.flush_i;
  assign w_fp_we     = w_head_valid && !w_head_int;
  assign w_int_valid = w_head_valid && w_head_int;
  assign w_pop       = w_fp_we || (w_int_valid && bus.int_ready_i);

  assign bus.in_ready_o  = !w_full;
  assign bus.count_o     = w_count;
  assign bus.busy_o      = w_head_valid;
  assign bus.fp_we_o     = w_fp_we;
  assign bus.int_valid_o = w_int_valid;
  assign bus.fp_waddr_o  = w_head_valid ? r_rd[w_head_idx]   : '0;
  assign bus.fp_wdata_o  = w_head_valid ? r_data[w_head_idx] : '0;
  assign bus.int_waddr_o = w_head_valid ? r_rd[w_head_idx]   : '0;
  assign bus.int_wdata_o = w_head_valid ? r_data[w_head_idx] : '0;
  assign bus.chk_hit_o   = w_hit;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [IDX_W-1:0] v_off;
    w_hit = 1'b0;
    v_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off = IDX_W'(i) - w_head_idx;
      if (({1'b0, v_off} < w_count) && !r_int[i] && (r_rd[i] == bus.chk_rd_i))
        w_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (bus.flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Payload is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[w_wr_idx] <= bus.in_data_i;
      r_rd[w_wr_idx]   <= bus.in_rd_i;
      r_int[w_wr_idx]  <= bus.in_int_i;
    end
  end

`ifdef FP_WB_FFLAGS_EN
  logic [4:0] r_status [DEPTH];
  logic [4:0] r_fflags;
  logic       w_pop_flags;

  assign w_pop_flags  = w_pop && !bus.flush_i;
  assign bus.fflags_o = r_fflags;

  always_ff @(posedge clk_i) begin
    if (w_push) r_status[w_wr_idx] <= bus.in_status_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_fflags <= '0;
    else if (bus.fflags_clr_i)
      r_fflags <= w_pop_flags ? r_status[w_head_idx] : 5'b0;
    else if (w_pop_flags)
      r_fflags <= r_fflags | r_status[w_head_idx];
  end
`else
  logic w_unused;
  assign w_unused     = ^{bus.in_status_i, bus.fflags_clr_i};
  assign bus.fflags_o = '0;
`endif
endmodule

// File: tb/tb_fp_wb_queue.sv
// Randomised and directed bench for fp_wb_queue; a monitor at the falling edge
// compares the DUT against an ordered list of queued results and a flag model.
module tb_fp_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int W      = DATA_W + 11;  // {int, rd, data, status}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();
  fp_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] stim_q[$];
  logic [4:0]   exp_flags = '0;
  bit           mon_en = 1'b0;
  int           n_pass = 0;
  int           n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic drive(input logic v, input logic i, input logic [4:0] rd,
                       input logic [DATA_W-1:0] d, input logic [4:0] st, input logic fl,
                       input logic clr, input logic irdy, input logic [4:0] chk);
    logic v_eff;
    v_eff = v && bus.in_ready_o;
    bus.in_valid_i   = v_eff;
    bus.in_int_i     = i;
    bus.in_rd_i      = rd;
    bus.in_data_i    = d;
    bus.in_status_i  = st;
    bus.flush_i      = fl;
    bus.fflags_clr_i = clr;
    bus.int_ready_i  = irdy;
    bus.chk_rd_i     = chk;
    if (v_eff && !fl) stim_q.push_back({i, rd, d, st});
  endtask

  task automatic idle(input logic irdy);
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b0, irdy, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare this cycle's outputs with the model, then advance the model.
  always @(negedge clk) begin : monitor
    logic [W-1:0] h;
    logic         pop, hit;
    if (mon_en && !rst) begin
      hit = 1'b0;
      foreach (exp_q[k]) begin
        h = exp_q[k];
        if (!h[W-1] && h[W-2 -: 5] == bus.chk_rd_i) hit = 1'b1;
      end
      check("count", bus.count_o, exp_q.size());
      check("in_ready", bus.in_ready_o, exp_q.size() != DEPTH);
      check("busy", bus.busy_o, exp_q.size() != 0);
      check("chk_hit", bus.chk_hit_o, hit);
      check("fflags", bus.fflags_o, exp_flags);
      pop = 1'b0;
      h   = '0;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        check("fp_we", bus.fp_we_o, !h[W-1]);
        check("int_valid", bus.int_valid_o, h[W-1]);
        check("fp_waddr", bus.fp_waddr_o, h[W-2 -: 5]);
        check("fp_wdata", bus.fp_wdata_o, h[DATA_W+4:5]);
        check("int_waddr", bus.int_waddr_o, h[W-2 -: 5]);
        check("int_wdata", bus.int_wdata_o, h[DATA_W+4:5]);
        pop = !h[W-1] || bus.int_ready_i;
      end else begin
        check("empty_fp_we", bus.fp_we_o, 0);
        check("empty_int_valid", bus.int_valid_o, 0);
        check("empty_addr", {bus.fp_waddr_o, bus.int_waddr_o}, 0);
        check("empty_data", {bus.fp_wdata_o, bus.int_wdata_o}, 0);
      end
`ifdef FP_WB_FFLAGS_EN
      if (bus.fflags_clr_i) exp_flags = (pop && !bus.flush_i) ? h[4:0] : 5'b0;
      else if (pop && !bus.flush_i) exp_flags = exp_flags | h[4:0];
`endif
      if (pop) void'(exp_q.pop_front());
      if (bus.flush_i) begin
        exp_q.delete();
        stim_q.delete();
      end else begin
        while (stim_q.size() > 0) exp_q.push_back(stim_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    logic [4:0] f_before;
    logic [4:0] f_req;
    idle(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_count", bus.count_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_fflags", bus.fflags_o, 0);
    check("rst_we_valid", {bus.fp_we_o, bus.int_valid_o, bus.chk_hit_o}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single FP push and its one-cycle latency.
    step(); drive(1'b1, 1'b0, 5'd3, 32'h3F80_0000, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    step(); idle(1'b1);
    #1;
    check("lat_fp_we", bus.fp_we_o, 1);
    check("lat_fp_waddr", bus.fp_waddr_o, 3);
    check("lat_fp_wdata", bus.fp_wdata_o, 32'h3F80_0000);
    step(); idle(1'b1);
    check("lat_count0", bus.count_o, 0);

    // Pending FP rd=7 behind a stalled integer head.
    step(); drive(1'b1, 1'b1, 5'd1, 32'h11, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7);
    step(); drive(1'b1, 1'b0, 5'd7, 32'h77, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7);
    step(); drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7);
    #1;
    check("haz_hit7", bus.chk_hit_o, 1);
    bus.chk_rd_i = 5'd8;
    #1;
    check("haz_hit8", bus.chk_hit_o, 0);
    repeat (3) begin step(); idle(1'b1); end

    // Fill with stalled integer results, then drain in order.
    for (int k = 0; k < 4; k++) begin
      step(); drive(1'b1, 1'b1, 5'(10 + k), $urandom, 5'($urandom_range(0, 31)),
                    1'b0, 1'b0, 1'b0, 5'd0);
    end
    step(); idle(1'b0);
    check("full_count", bus.count_o, 4);
    check("full_in_ready", bus.in_ready_o, 0);
    step(); idle(1'b0);
    check("full_hold", bus.in_ready_o, 0);
    step(); idle(1'b1);
    step(); idle(1'b1);
    check("drain_ready", bus.in_ready_o, 1);
    check("drain_count3", bus.count_o, 3);
    repeat (3) begin step(); idle(1'b1); end
    check("drain_count0", bus.count_o, 0);

    // Flush with three queued entries and a concurrent push.
    for (int k = 0; k < 3; k++) begin
      step(); drive(1'b1, 1'b1, 5'(20 + k), $urandom, 5'd31, 1'b0, 1'b0, 1'b0, 5'd0);
    end
    step();
    f_before = bus.fflags_o;
    drive(1'b1, 1'b0, 5'd9, 32'h99, 5'd31, 1'b1, 1'b0, 1'b0, 5'd0);
    step(); idle(1'b0);
    check("flush_count", bus.count_o, 0);
    check("flush_no_write", {bus.fp_we_o, bus.int_valid_o}, 0);
    check("flush_fflags", bus.fflags_o, f_before);

    // Flag accrual, then clear coinciding with a pop.
    step(); drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0);
    step(); drive(1'b1, 1'b0, 5'd4, 32'h1, 5'b00001, 1'b0, 1'b0, 1'b1, 5'd0);
    step(); drive(1'b1, 1'b0, 5'd5, 32'h2, 5'b10000, 1'b0, 1'b0, 1'b1, 5'd0);
    step(); idle(1'b1);
    step(); idle(1'b1);
`ifdef FP_WB_FFLAGS_EN
    f_req = 5'b10001;
`else
    f_req = 5'b00000;
`endif
    check("flags_accrue", bus.fflags_o, f_req);
    step(); drive(1'b1, 1'b0, 5'd6, 32'h3, 5'b00100, 1'b0, 1'b0, 1'b1, 5'd0);
    step(); drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0);
    step(); idle(1'b1);
`ifdef FP_WB_FFLAGS_EN
    f_req = 5'b00100;
`else
    f_req = 5'b00000;
`endif
    check("flags_clr_pop", bus.fflags_o, f_req);

    // Asynchronous reset between edges with two entries queued.
    step(); drive(1'b1, 1'b1, 5'd2, 32'hAA, 5'd1, 1'b0, 1'b0, 1'b0, 5'd5);
    step(); drive(1'b1, 1'b0, 5'd5, 32'hBB, 5'd1, 1'b0, 1'b0, 1'b0, 5'd5);
    step(); drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5);
    #1;
    check("pre_rst_hit", bus.chk_hit_o, 1);
    rst = 1'b1;
    #1;
    check("arst_count", bus.count_o, 0);
    check("arst_ready_busy", {bus.in_ready_o, bus.busy_o}, 2'b10);
    check("arst_we_valid_hit", {bus.fp_we_o, bus.int_valid_o, bus.chk_hit_o}, 0);
    check("arst_fflags", bus.fflags_o, 0);
    check("arst_addr_data", {bus.fp_waddr_o, bus.fp_wdata_o, bus.int_waddr_o, bus.int_wdata_o}, 0);
    exp_q.delete();
    stim_q.delete();
    exp_flags = '0;
    idle(1'b1);
    step();
    rst = 1'b0;

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      step();
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)),
            $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 49) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 15)));
    end

    for (int n = 0; n < 50 && (exp_q.size() != 0 || stim_q.size() != 0); n++) begin
      step(); idle(1'b1);
    end
    check("final_drain", exp_q.size(), 0);
    step();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fp_wb_queue.md
# fp_wb_queue

Writeback queue placed directly downstream of the FPU wrapper. It accepts each completed FPU result (data, destination register, destination file, exception status) and buffers it in an in-order FIFO. It drains entries to the FP register-file write port or to the integer writeback port. It also tracks pending FP destinations for hazard checks and accumulates sticky IEEE exception flags.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `DATA_W`, 32: result width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `in_valid_i` in 1: FPU result valid (FPU `out_valid_o`).
- `in_ready_o` out 1: queue can accept.
- `in_data_i` in DATA_W: result value.
- `in_rd_i` in 5: destination register index.
- `in_int_i` in 1: 1 = integer destination (compare, classify, convert-to-int, move-to-int); 0 = FP destination.
- `in_status_i` in 5: {NV,DZ,OF,UF,NX}.
- `flush_i` in 1: discard all queued entries.
- `fp_we_o` out 1: FP regfile write enable.
- `fp_waddr_o` out 5: FP regfile write address.
- `fp_wdata_o` out DATA_W: FP regfile write data.
- `int_valid_o` out 1: integer writeback request.
- `int_ready_i` in 1: integer writeback port accepts.
- `int_waddr_o` out 5: integer destination register.
- `int_wdata_o` out DATA_W: integer writeback data.
- `chk_rd_i` in 5: FP register index to check.
- `chk_hit_o` out 1: a queued FP-destination entry targets `chk_rd_i`.
- `fflags_o` out 5: sticky accrued exception flags.
- `fflags_clr_i` in 1: clear sticky flags.
- `count_o` out $clog2(DEPTH)+1: occupancy.
- `busy_o` out 1: occupancy ≠ 0.

## Operation
- Circular buffer with read/write pointers that are $clog2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty.
- Push: when `in_valid_i && in_ready_o && !flush_i`, write the entry at the write pointer and increment it. `in_ready_o = (count_o != DEPTH)`. It depends only on registered state, with no combinational path from any input.
- Head drain, FP destination: `fp_we_o = head_valid && !head_int`. The FP regfile always accepts, so the entry pops in the same cycle.
- Head drain, integer destination: `int_valid_o = head_valid && head_int`. The entry pops on `int_valid_o && int_ready_i`. `int_valid_o` and the head contents stay stable until accepted.
- Only the head entry drains; order is strict, with at most one pop per cycle.
- Push and pop in the same cycle: `count_o` is unchanged. This is legal at any occupancy except full, where push is blocked.
- Write ports not in use: their address and data outputs carry head contents, or 0 when empty.
- `chk_hit_o`: OR over all valid entries of `(!int && rd == chk_rd_i)`, combinational. An entry popping this cycle still counts.
- Flush: at the next edge the pointers reset to equal and all entries are invalidated. A concurrent push is dropped. A concurrent pop does not contribute flags.
- The upstream FPU runs with `out_ready_i` tied high. The issue logic must stall FPU issue whenever `in_ready_o` is low. The queue never sees a valid input it cannot accept.

## Timing
- Reset values: `in_ready_o`=1, `busy_o`=0, `count_o`=0, `fp_we_o`=0, `int_valid_o`=0, `chk_hit_o`=0, `fflags_o`=0, all addr/data outputs 0.
- Latency: a result pushed at edge N appears at the head outputs in cycle N+1 if the queue was empty. It writes the FP regfile at edge N+1.
- Throughput: one entry per cycle sustained for FP destinations.
- Integer entry stalled by `int_ready_i`=0: the queue fills, and `in_ready_o` deasserts the cycle after occupancy reaches DEPTH.
- Reset asserted mid-operation clears everything asynchronously. Outputs take reset values without waiting for a clock edge.

## Configuration
- `FP_WB_FFLAGS_EN` defined: per-entry 5-bit status storage. `fflags_o` ORs in a popped entry's status at the pop edge. `fflags_clr_i` clears the flags. If clear and pop happen in the same cycle, the result is the popped entry's status only.
- `FP_WB_FFLAGS_EN` undefined: `in_status_i` is ignored, no status storage exists, `fflags_o` is constant 0, and `fflags_clr_i` is ignored.

## Test plan
- Single FP push: rd=3, data=0x3F800000 → next cycle `fp_we_o`=1, `fp_waddr_o`=3, `fp_wdata_o`=0x3F800000; `count_o` returns to 0.
- Integer stall: push 4 int entries with `int_ready_i`=0 → `count_o`=4, `in_ready_o`=0. Raise `int_ready_i` → entries drain in order, one per cycle, and `in_ready_o`=1 after the first pop.
- Hazard: queue holds FP rd=7 behind a stalled int head; `chk_rd_i`=7 → `chk_hit_o`=1; `chk_rd_i`=8 → 0.
- Flush with push: flush asserted with 3 entries and a simultaneous push → next cycle `count_o`=0, no write, `fflags_o` unchanged.
- Flags (macro on): pop statuses 0b00001 then 0b10000 → `fflags_o`=0b10001. Clear in the same cycle as a pop with status 0b00100 → `fflags_o`=0b00100.
- Async reset: assert `rst_i` between edges with 2 entries queued → all outputs at reset values immediately.
